// File: rtl/sobolrng_mdim.sv
// Multi-dimensional Sobol sequence generator with an internal index, programmable
// direction vectors and shift masks, Gray-code skip-ahead and a wrap pulse.
module sobolrng_mdim #(
    parameter int BITWIDTH = 8,
    parameter int NUM_DIM  = 2,
    parameter int DIM_W    = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1,
    parameter int IDX_W    = (BITWIDTH > 1) ? $clog2(BITWIDTH) : 1
) (
    input  logic                         iClk,
    input  logic                         iRst,
    input  logic                         iEn,
    input  logic                         iClr,
    input  logic                         iLoad,
    input  logic [BITWIDTH-1:0]          iLoadIdx,
    input  logic                         iCfgWe,
    input  logic                         iCfgSel,
    input  logic [DIM_W-1:0]             iCfgDim,
    input  logic [IDX_W-1:0]             iCfgIdx,
    input  logic [BITWIDTH-1:0]          iCfgData,
    output logic [NUM_DIM*BITWIDTH-1:0]  oRand,
    output logic [BITWIDTH-1:0]          oCnt,
    output logic                         oWrap
);

    localparam logic [BITWIDTH-1:0] ALL_ONES = {BITWIDTH{1'b1}};
    localparam logic [BITWIDTH-1:0] ONE      = {{(BITWIDTH-1){1'b0}}, 1'b1};
    localparam logic [BITWIDTH-1:0] ZERO     = {BITWIDTH{1'b0}};

    logic [BITWIDTH-1:0]         v_q    [NUM_DIM][BITWIDTH];
    logic [BITWIDTH-1:0]         v_d    [NUM_DIM][BITWIDTH];
    logic [BITWIDTH-1:0]         m_q    [NUM_DIM];
    logic [BITWIDTH-1:0]         m_d    [NUM_DIM];
    logic [BITWIDTH-1:0]         s_q    [NUM_DIM];
    logic [BITWIDTH-1:0]         s_d    [NUM_DIM];
    logic [BITWIDTH-1:0]         step_s [NUM_DIM];
    logic [BITWIDTH-1:0]         load_s [NUM_DIM];
    logic [BITWIDTH-1:0]         cnt_q;
    logic [BITWIDTH-1:0]         cnt_d;
    logic                        wrap_q;
    logic                        wrap_d;
    logic [NUM_DIM*BITWIDTH-1:0] rand_q;
    logic [NUM_DIM*BITWIDTH-1:0] rand_d;
    logic [BITWIDTH-1:0]         oh_s;
    logic [BITWIDTH-1:0]         gray_s;

    // Van der Corput direction vector for index k: a single bit walking down from the MSB.
    function automatic logic [BITWIDTH-1:0] vdc_vec(input int k);
        logic [BITWIDTH-1:0] r;
        r = ZERO;
        r[BITWIDTH-1-k] = 1'b1;
        return r;
    endfunction

    assign oRand = rand_q;
    assign oCnt  = cnt_q;
    assign oWrap = wrap_q;

    // Step and skip-ahead contributions, both taken from the pre-write direction vectors.
    always_comb begin
        oh_s   = ~cnt_q & (cnt_q + ONE);
        gray_s = iLoadIdx ^ (iLoadIdx >> 1);
        for (int d = 0; d < NUM_DIM; d++) begin
            step_s[d] = ZERO;
            load_s[d] = ZERO;
            for (int k = 0; k < BITWIDTH; k++) begin
                step_s[d] = step_s[d] | (oh_s[k]   ? v_q[d][k] : ZERO);
                load_s[d] = load_s[d] ^ (gray_s[k] ? v_q[d][k] : ZERO);
            end
        end
    end

    // Configuration writes; out-of-range dimension or index simply matches nothing.
    always_comb begin
        v_d = v_q;
        m_d = m_q;
        for (int d = 0; d < NUM_DIM; d++) begin
            if (iCfgWe && iCfgSel && (int'(iCfgDim) == d)) begin
                m_d[d] = iCfgData;
            end else begin
                m_d[d] = m_q[d];
            end
            for (int k = 0; k < BITWIDTH; k++) begin
                if (iCfgWe && !iCfgSel && (int'(iCfgDim) == d) && (int'(iCfgIdx) == k)) begin
                    v_d[d][k] = iCfgData;
                end else begin
                    v_d[d][k] = v_q[d][k];
                end
            end
        end
    end

    // Sequence commands in priority order clear > load > step; the output image follows.
    always_comb begin
        s_d    = s_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        rand_d = ZERO == ZERO ? {(NUM_DIM*BITWIDTH){1'b0}} : {(NUM_DIM*BITWIDTH){1'b0}};
        if (iClr) begin
            cnt_d = ZERO;
            for (int d = 0; d < NUM_DIM; d++) s_d[d] = ZERO;
        end else if (iLoad) begin
            cnt_d = iLoadIdx;
            s_d   = load_s;
        end else if (iEn) begin
            if (cnt_q == ALL_ONES) begin
                cnt_d  = ZERO;
                wrap_d = 1'b1;
                for (int d = 0; d < NUM_DIM; d++) s_d[d] = ZERO;
            end else begin
                cnt_d = cnt_q + ONE;
                for (int d = 0; d < NUM_DIM; d++) s_d[d] = s_q[d] ^ step_s[d];
            end
        end else begin
            cnt_d = cnt_q;
        end
        for (int d = 0; d < NUM_DIM; d++) begin
            rand_d[d*BITWIDTH +: BITWIDTH] = s_d[d] ^ m_d[d];
        end
    end

    // State registers; reset also restores the default configuration.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q  <= ZERO;
            wrap_q <= 1'b0;
            rand_q <= {(NUM_DIM*BITWIDTH){1'b0}};
            for (int d = 0; d < NUM_DIM; d++) begin
                s_q[d] <= ZERO;
                m_q[d] <= ZERO;
                for (int k = 0; k < BITWIDTH; k++) begin
                    v_q[d][k] <= vdc_vec(k);
                end
            end
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            rand_q <= rand_d;
            s_q    <= s_d;
            m_q    <= m_d;
            v_q    <= v_d;
        end
    end

endmodule

// File: tb/tb_sobolrng_mdim.sv
// Directed bench for sobolrng_mdim (BITWIDTH=8, NUM_DIM=2) with hand-computed expectations.
module tb_sobolrng_mdim;

    logic        iClk = 1'b0;
    logic        iRst, iEn, iClr, iLoad, iCfgWe, iCfgSel;
    logic [7:0]  iLoadIdx, iCfgData;
    logic [1:0]  iCfgDim;
    logic [2:0]  iCfgIdx;
    logic [15:0] oRand;
    logic [7:0]  oCnt;
    logic        oWrap;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    sobolrng_mdim #(.BITWIDTH(8), .NUM_DIM(2), .DIM_W(2), .IDX_W(3)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .iLoad(iLoad),
        .iLoadIdx(iLoadIdx), .iCfgWe(iCfgWe), .iCfgSel(iCfgSel), .iCfgDim(iCfgDim),
        .iCfgIdx(iCfgIdx), .iCfgData(iCfgData), .oRand(oRand), .oCnt(oCnt), .oWrap(oWrap)
    );

    always #5 iClk = ~iClk;

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] ec, input logic ew);
        chk({tag, " dim0"}, {8'h00, oRand[7:0]}, {8'h00, e0});
        chk({tag, " dim1"}, {8'h00, oRand[15:8]}, {8'h00, e1});
        chk({tag, " cnt"}, {8'h00, oCnt}, {8'h00, ec});
        chk({tag, " wrap"}, {15'h0000, oWrap}, {15'h0000, ew});
    endtask

    task automatic idle();
        iEn = 1'b0; iClr = 1'b0; iLoad = 1'b0; iCfgWe = 1'b0; iRst = 1'b0;
    endtask

    logic [7:0] e0_t1 [4] = '{8'h80, 8'hC0, 8'h40, 8'h60};
    logic [7:0] e1_t2 [4] = '{8'h80, 8'h40, 8'hC0, 8'h60};
    logic [7:0] v1_t2 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hF0, 8'h88, 8'hCC, 8'hAA, 8'hFF};

    initial begin
        idle();
        iRst = 1'b1; iLoadIdx = 8'h00; iCfgSel = 1'b0; iCfgDim = 2'd0;
        iCfgIdx = 3'd0; iCfgData = 8'h00;
        cyc(); cyc();
        iRst = 1'b0;
        cyc();
        chk_out("reset", 8'h00, 8'h00, 8'h00, 1'b0);

        // 1: van der Corput stepping on both dimensions
        iEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_out("t1 step", e0_t1[i], e0_t1[i], 8'(i + 1), 1'b0);
        end
        iEn = 1'b0;

        // 2: program dim1 vectors, restart, step
        iCfgWe = 1'b1; iCfgSel = 1'b0; iCfgDim = 2'd1;
        for (int k = 0; k < 8; k++) begin
            iCfgIdx = 3'(k); iCfgData = v1_t2[k];
            cyc();
        end
        iCfgWe = 1'b0;
        iClr = 1'b1; cyc(); iClr = 1'b0;
        chk_out("t2 clr", 8'h00, 8'h00, 8'h00, 1'b0);
        iEn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_out("t2 step", e0_t1[i], e1_t2[i], 8'(i + 1), 1'b0);
        end
        iEn = 1'b0;

        // 3: skip-ahead and equivalence with stepping
        iLoad = 1'b1; iLoadIdx = 8'd5; cyc(); iLoad = 1'b0;
        chk_out("t3 load5", 8'hE0, 8'hE0, 8'd5, 1'b0);
        iEn = 1'b1; cyc(); iEn = 1'b0;
        chk_out("t3 step6", 8'hA0, 8'h20, 8'd6, 1'b0);
        iLoad = 1'b1; iLoadIdx = 8'd19; cyc(); iLoad = 1'b0;
        chk_out("t3 load19", 8'h58, 8'hB8, 8'd19, 1'b0);
        iClr = 1'b1; cyc(); iClr = 1'b0;
        iEn = 1'b1;
        for (int i = 0; i < 19; i++) cyc();
        iEn = 1'b0;
        chk_out("t3 walk19", 8'h58, 8'hB8, 8'd19, 1'b0);

        // 4: wrap at the last index
        iLoad = 1'b1; iLoadIdx = 8'hFF; cyc(); iLoad = 1'b0;
        chk_out("t4 loadFF", 8'h01, 8'hFF, 8'hFF, 1'b0);
        iEn = 1'b1; cyc(); iEn = 1'b0;
        chk_out("t4 wrap", 8'h00, 8'h00, 8'h00, 1'b1);
        cyc();
        chk_out("t4 idle", 8'h00, 8'h00, 8'h00, 1'b0);
        iEn = 1'b1; cyc(); iEn = 1'b0;
        chk_out("t4 after", 8'h80, 8'h80, 8'd1, 1'b0);

        // 5: shift mask, command priority, out-of-range writes
        iCfgWe = 1'b1; iCfgSel = 1'b1; iCfgDim = 2'd0; iCfgData = 8'hFF; cyc(); iCfgWe = 1'b0;
        chk_out("t5 mask", 8'h7F, 8'h80, 8'd1, 1'b0);
        iClr = 1'b1; iLoad = 1'b1; iLoadIdx = 8'd5; iEn = 1'b1; cyc(); idle();
        chk_out("t5 prio", 8'hFF, 8'h00, 8'h00, 1'b0);
        iCfgWe = 1'b1; iCfgSel = 1'b1; iCfgDim = 2'd3; iCfgData = 8'h55; cyc();
        iCfgSel = 1'b0; iCfgIdx = 3'd0; cyc(); iCfgWe = 1'b0;
        chk_out("t5 dim3", 8'hFF, 8'h00, 8'h00, 1'b0);
        iEn = 1'b1; cyc(); iEn = 1'b0;
        chk_out("t5 step", 8'h7F, 8'h80, 8'd1, 1'b0);
        iCfgWe = 1'b1; iCfgSel = 1'b1; iCfgDim = 2'd0; iCfgData = 8'h00; iClr = 1'b1;
        cyc(); idle();
        chk_out("t5 unmask", 8'h00, 8'h00, 8'h00, 1'b0);

        // 6: write/step collision, then reset mid-run
        iCfgWe = 1'b1; iCfgSel = 1'b0; iCfgDim = 2'd0; iCfgIdx = 3'd0; iCfgData = 8'h01;
        iEn = 1'b1; cyc(); idle();
        chk_out("t6 oldvec", 8'h80, 8'h80, 8'd1, 1'b0);
        iClr = 1'b1; cyc(); iClr = 1'b0;
        iEn = 1'b1; cyc();
        chk_out("t6 newvec", 8'h01, 8'h80, 8'd1, 1'b0);
        cyc(); iEn = 1'b0;
        chk_out("t6 step2", 8'h41, 8'h40, 8'd2, 1'b0);
        iRst = 1'b1; iEn = 1'b1; iCfgWe = 1'b1; iCfgData = 8'h33; cyc(); idle();
        chk_out("t6 reset", 8'h00, 8'h00, 8'h00, 1'b0);
        iEn = 1'b1; cyc();
        chk_out("t6 dflt1", 8'h80, 8'h80, 8'd1, 1'b0);
        cyc(); iEn = 1'b0;
        chk_out("t6 dflt2", 8'hC0, 8'hC0, 8'd2, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
